load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 58 +++++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_extend.sv | 32 +++
 rtl/load_store_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the load/store unit: widths, funct3 codes, FSM states, request latch.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    // RV32I load/store width and sign codes
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_DONE,
        LSU_FAULT
    } lsu_state_e;

    // Request fields still needed after the memory request has been issued
    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lsu_req_t;

    // Illegal width code or an access not aligned to its own size
    function automatic logic req_faults(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return offset[0];
            F3_W:        return offset != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by a store of 1/2/4 bytes
    function automatic logic [BE_W-1:0] store_be(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return BE_W'(4'b0001 << offset);
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data so every lane carries it
    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request handshake from the control FSM plus the word-wide memory port of the LSU.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            req_valid;
    logic            req_write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] write_data;
    logic            req_ready;
    logic            done;
    logic            fault;
    logic [XLEN-1:0] load_data;

    logic            mem_valid;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [BE_W-1:0] mem_be;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    // LSU side
    modport slave (
        input  req_valid, req_write, funct3, address, write_data, mem_rvalid, mem_rdata,
        output req_ready, done, fault, load_data, mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Core and memory side
    modport master (
        output req_valid, req_write, funct3, address, write_data, mem_rvalid, mem_rdata,
        input  req_ready, done, fault, load_data, mem_valid, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/load_extend.sv
// Picks the addressed lane out of a read word and sign- or zero-extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_shifted = i_rdata >> {i_addr, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_shifted[15:0];

    // Extension by width code; aligned words have offset 0 so the shift is a pass-through
    always_comb begin
        o_result = '0;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_W:    o_result = w_shifted;
            F3_BU:   o_result = {24'h0, w_byte};
            F3_HU:   o_result = {16'h0, w_half};
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues a single word access, times out stuck accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e      r_state;
    lsu_req_t        r_req;
    logic [CNT_W-1:0] r_cnt;
    logic            r_req_ready;
    logic            r_done;
    logic            r_fault;
    logic            r_mem_valid;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [BE_W-1:0] r_mem_be;
    logic [XLEN-1:0] r_load_data;
    logic [XLEN-1:0] w_ext;
    logic            w_last_cycle;

    assign w_last_cycle = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_extend u_load_extend (
        .i_funct3 (r_req.funct3),
        .i_addr   (r_req.offset),
        .i_rdata  (bus.mem_rdata),
        .o_result (w_ext)
    );

    // Request FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LSU_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_load_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (bus.req_valid) begin
                        r_req.write  <= bus.req_write;
                        r_req.funct3 <= bus.funct3;
                        r_req.offset <= bus.address[1:0];
                        r_cnt        <= '0;
                        r_req_ready  <= 1'b0;
                        if (req_faults(bus.funct3, bus.address[1:0])) begin
                            r_state <= LSU_FAULT;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
                            r_state     <= LSU_ACCESS;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= bus.req_write;
                            r_mem_addr  <= {bus.address[XLEN-1:2], 2'b00};
                            r_mem_be    <= bus.req_write ? store_be(bus.funct3[1:0], bus.address[1:0]) : '0;
                            r_mem_wdata <= bus.req_write ? store_data(bus.funct3[1:0], bus.write_data) : '0;
                        end
                    end
                end
                LSU_ACCESS: begin
                    // An ack on the last allowed cycle still completes normally
                    if (bus.mem_rvalid || w_last_cycle) begin
                        r_state     <= bus.mem_rvalid ? LSU_DONE : LSU_FAULT;
                        r_done      <= 1'b1;
                        r_fault     <= ~bus.mem_rvalid;
                        r_mem_valid <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                        if (bus.mem_rvalid && !r_req.write) begin
                            r_load_data <= w_ext;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LSU_DONE, LSU_FAULT: begin
                    r_state     <= LSU_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= LSU_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.done      = r_done;
    assign bus.fault     = r_fault;
    assign bus.load_data = r_load_data;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;

endmodule
